stress_demux: RTL and testbench
===============================

Name: stress_demux

Overview:
- Registered 1-to-2 demultiplexer for 8-bit stress samples. It is the distributing counterpart of the stress calculator's 2:1 select path.
- A single upstream sample stream is steered to channel A or channel B, chosen either by an explicit select or by automatic alternation.
- Each channel output is buffered in a 2-entry FIFO with a valid/ready handshake and has its own delivered-sample counter.
- Sits between the shared sample source and the two per-channel stress accumulators.

Parameters:
- DATA_W, 8, sample width in bits.
- CNT_W, 8, width of each per-channel delivered-sample counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = steering by sel; 1 = automatic A/B alternation.
- sel  in  1  channel select when mode=0 (0 = A, 1 = B).
- in_data  in  DATA_W  upstream sample.
- in_valid  in  1  upstream sample present.
- in_ready  out  1  block accepts in_data this cycle.
- a_data  out  DATA_W  head sample of channel A.
- a_valid  out  1  channel A FIFO not empty.
- a_ready  in  1  channel A consumer takes the head sample.
- b_data  out  DATA_W  head sample of channel B.
- b_valid  out  1  channel B FIFO not empty.
- b_ready  in  1  channel B consumer takes the head sample.
- a_count  out  CNT_W  number of samples popped from A, modulo 2^CNT_W.
- b_count  out  CNT_W  number of samples popped from B, modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_n=0), applied immediately and regardless of any transfer in progress:
  - both FIFOs empty, so a_valid=b_valid=0;
  - a_data=b_data=0;
  - a_count=b_count=0;
  - toggle=0, so A is the next auto target.
- Target selection:
  - target = mode ? toggle : sel, evaluated combinationally each cycle.
- Upstream handshake:
  - in_ready = NOT full(target). It depends only on the current FIFO state, never on a_ready/b_ready, so there is no combinational ready-to-ready path.
  - A sample is accepted only when in_valid=1 and in_ready=1. in_data is sampled at that edge and pushed into the target FIFO.
  - When in_valid=0, no FIFO, toggle or counter changes due to the input side.
- Toggle (alternation state):
  - Flips only on an accepted sample while mode=1.
  - Unchanged on stalls (in_valid=1, in_ready=0) and whenever mode=0.
  - Switching mode does not reset toggle. Auto mode resumes from the last toggle value, and the change takes effect on the next cycle's target.
- Latency:
  - A sample accepted at edge N appears as head (x_valid=1) after edge N if that FIFO was empty, i.e. 1 cycle.
  - Order within a channel is strictly FIFO.
- Output handshake, per channel:
  - Pop when x_valid=1 and x_ready=1.
  - x_data holds stable while x_valid=1 and x_ready=0.
  - x_ready while x_valid=0 has no effect.
- Boundary conditions:
  - Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
  - Full FIFO with a pop in the same cycle: the push is still refused (in_ready=0 that cycle); the pop completes.
  - Channel A full while the target is B: input flow continues into B. Channel A blocks the input only when A is the target.
  - Both FIFOs full in auto mode: the stall holds on the current target and toggle does not advance.
- Counters:
  - x_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
  - Counters are independent; simultaneous pops on A and B increment both.

Decomposition:
- Shared package/header holds DATA_W and CNT_W defaults, plus channel encodings CH_A=1'b0 and CH_B=1'b1.
- One sub-module, stress_chan_fifo: 2-entry FIFO with push/pop, full/empty flags, head data and a wrapping pop counter. It is instantiated twice.
- Top level contains only the target/toggle logic and the in_ready mux.

Test Plan:
- Reset release, mode=0, sel=0, in_data=0x3C for one cycle, a_ready=1 -> a_valid=1 with a_data=0x3C one cycle later, b_valid stays 0, a_count=1 after the pop.
- mode=1, a_ready=b_ready=1, stream 0x01,0x02,0x03,0x04 back-to-back -> A outputs 0x01,0x03; B outputs 0x02,0x04; a_count=b_count=2.
- mode=0, sel=1, b_ready=0, push 0x10,0x11,0x12 -> in_ready drops after 2 accepts; b_data holds 0x10. Raise b_ready -> 0x10 then 0x11 pop, and 0x12 is accepted only after full clears.
- A full with a_ready=0, mode=0, sel=1 -> in_ready=1 and samples flow to B; switch sel=0 -> in_ready=0 immediately.
- 256 pops on A -> a_count reaches 255, then wraps to 0.
- Assert rst_n=0 mid-stream with both FIFOs holding data -> all valids and counts go to 0 immediately (asynchronously); after release, auto mode targets A first.

Source files
------------

// File: rtl/stress_demux_pkg.sv
// Shared definitions for the stress sample demultiplexer: default widths and
// the channel encoding used for steering.
package stress_demux_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic {
      CH_A = 1'b0,
      CH_B = 1'b1
   } chan_e;

endpackage

// File: rtl/stress_chan_fifo.sv
// Two-entry per-channel output buffer with valid/ready pop side, full/empty
// flags, head data and a wrapping count of delivered samples.
module stress_chan_fifo
   import stress_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_ready_i,
   output logic              full_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        used_q, used_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (used_q == 2'd2);
   assign valid_o = (used_q != 2'd0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = valid_o & pop_ready_i;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      used_d   = used_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
         cnt_d    = cnt_q + 1'b1;
      end
      if (do_push && !do_pop)      used_d = used_q + 2'd1;
      else if (do_pop && !do_push) used_d = used_q - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         used_q   <= 2'd0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         used_q   <= used_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: storage is reset because the head entry is visible on data_o and must read zero out of reset.
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/stress_demux.sv
// Registered 1-to-2 demultiplexer: steers one upstream sample stream into
// channel A or B by explicit select or automatic alternation.
module stress_demux
   import stress_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic              sel,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [DATA_W-1:0] b_data,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [CNT_W-1:0]  a_count,
   output logic [CNT_W-1:0]  b_count
);

   chan_e target;
   logic  toggle_q, toggle_d;
   logic  a_full, b_full;
   logic  accept;
   logic  push_a, push_b;

   // in_ready looks only at the target's fill level, never at a_ready/b_ready.
   always_comb begin
      target   = chan_e'(mode ? toggle_q : sel);
      in_ready = (target == CH_A) ? ~a_full : ~b_full;
      accept   = in_valid & in_ready;
      push_a   = accept & (target == CH_A);
      push_b   = accept & (target == CH_B);
      toggle_d = toggle_q ^ (accept & mode);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) toggle_q <= 1'b0;
      else        toggle_q <= toggle_d;
   end

   stress_chan_fifo #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_chan_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_a),
      .push_data_i (in_data),
      .pop_ready_i (a_ready),
      .full_o      (a_full),
      .valid_o     (a_valid),
      .data_o      (a_data),
      .count_o     (a_count)
   );

   stress_chan_fifo #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_chan_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_b),
      .push_data_i (in_data),
      .pop_ready_i (b_ready),
      .full_o      (b_full),
      .valid_o     (b_valid),
      .data_o      (b_data),
      .count_o     (b_count)
   );

endmodule

// File: tb/tb_stress_demux.sv
// Scoreboard bench for stress_demux: stimulus pushes expected samples per
// channel, an independent monitor pops and compares on every output pop.
module tb_stress_demux;
   import stress_demux_pkg::*;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       mode     = 1'b0;
   logic       sel      = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic       a_ready  = 1'b0;
   logic       b_ready  = 1'b0;
   logic       in_ready;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic [7:0] a_count, b_count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] mdl_a_cnt = 8'd0;
   logic [7:0] mdl_b_cnt = 8'd0;
   logic       mdl_toggle = 1'b0;

   stress_demux #(.DATA_W(8), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .sel      (sel),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .a_count  (a_count),
      .b_count  (b_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every pop against the scoreboard and tracks counters.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_a.delete();
         exp_b.delete();
         mdl_a_cnt = 8'd0;
         mdl_b_cnt = 8'd0;
      end else begin
         check("a_count_track", a_count, mdl_a_cnt);
         check("b_count_track", b_count, mdl_b_cnt);
         if (a_valid && exp_a.size() == 0) check("a_valid_unexpected", a_valid, 0);
         else if (a_valid && a_ready) begin
            check("a_data_pop", a_data, exp_a.pop_front());
            mdl_a_cnt = mdl_a_cnt + 8'd1;
         end
         if (b_valid && exp_b.size() == 0) check("b_valid_unexpected", b_valid, 0);
         else if (b_valid && b_ready) begin
            check("b_data_pop", b_data, exp_b.pop_front());
            mdl_b_cnt = mdl_b_cnt + 8'd1;
         end
      end
   end

   // Offers one sample and waits (bounded) for the handshake; the bench's own
   // target/toggle model decides which channel must deliver it.
   task automatic send(input logic [7:0] d);
      logic tgt;
      bit   done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         tgt = mode ? mdl_toggle : sel;
         if (in_ready) begin
            if (tgt == CH_A) exp_a.push_back(d);
            else             exp_b.push_back(d);
            if (mode) mdl_toggle = ~mdl_toggle;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (exp_a.size() != 0 || exp_b.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      check("drain_done", exp_a.size() + exp_b.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_valid", a_valid, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_a_data", a_data, 0);
      check("rst_b_data", b_data, 0);
      check("rst_a_count", a_count, 0);
      check("rst_b_count", b_count, 0);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);

      // Single sample to A, 1-cycle latency
      mode = 1'b0; sel = 1'b0; a_ready = 1'b1;
      send(8'h3C);
      check("t1_a_valid", a_valid, 1);
      check("t1_a_data", a_data, 8'h3C);
      check("t1_b_valid", b_valid, 0);
      drain();
      check("t1_a_count", a_count, 1);

      // Auto alternation A,B,A,B
      mode = 1'b1; b_ready = 1'b1;
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      drain();
      check("t2_a_count", a_count, 3);
      check("t2_b_count", b_count, 2);

      // B fills, holds head, pop-while-full refuses push
      mode = 1'b0; sel = 1'b1; b_ready = 1'b0;
      send(8'h10); send(8'h11);
      in_valid = 1'b1; in_data = 8'h12;
      @(negedge clk);
      check("t3_full_in_ready", in_ready, 0);
      check("t3_b_head", b_data, 8'h10);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_b_hold", b_data, 8'h10);
      @(posedge clk); #1;
      b_ready = 1'b1;
      @(negedge clk);
      check("t3_full_pop_in_ready", in_ready, 0);
      @(posedge clk); #1;
      send(8'h12);
      drain();
      check("t3_b_count", b_count, 5);

      // A full while targeting B: flow continues; retarget A blocks at once
      a_ready = 1'b0; sel = 1'b0;
      send(8'h20); send(8'h21);
      sel = 1'b1;
      @(negedge clk);
      check("t4_a_full_tgt_b", in_ready, 1);
      @(posedge clk); #1;
      send(8'h30); send(8'h31);
      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0; in_valid = 1'b1; in_data = 8'h22;
      @(negedge clk);
      check("t4_a_full_tgt_a", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Fill B too, then stall in auto mode: toggle must stay on A
      b_ready = 1'b0; sel = 1'b1;
      send(8'h32); send(8'h33);
      mode = 1'b1; in_valid = 1'b1; in_data = 8'h40;
      @(negedge clk);
      check("t4_both_full_stall0", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_both_full_stall1", in_ready, 0);
      @(posedge clk); #1;
      a_ready = 1'b1;
      send(8'h40);
      b_ready = 1'b1;
      drain();

      // Asynchronous reset with both channels holding data
      mode = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
      sel = 1'b0; send(8'h50);
      sel = 1'b1; send(8'h51);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_a_valid", a_valid, 0);
      check("mid_rst_b_valid", b_valid, 0);
      check("mid_rst_a_count", a_count, 0);
      check("mid_rst_b_count", b_count, 0);
      check("mid_rst_a_data", a_data, 0);
      check("mid_rst_b_data", b_data, 0);
      mdl_toggle = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mode = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
      send(8'h60);
      check("post_rst_auto_a_valid", a_valid, 1);
      check("post_rst_auto_a_data", a_data, 8'h60);
      check("post_rst_auto_b_valid", b_valid, 0);

      // Counter wrap on A: 256 pops since reset
      mode = 1'b0; sel = 1'b0;
      for (int i = 1; i < 255; i++) send(8'(i));
      drain();
      check("wrap_a_count_255", a_count, 8'd255);
      send(8'hAA);
      drain();
      check("wrap_a_count_0", a_count, 8'd0);
      check("wrap_b_count", b_count, 8'd0);

      check("final_queues_empty", exp_a.size() + exp_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
